// File: rtl/element_delay_tracker.sv
// Converts per-element increment terms K_n into integer sample delays by an incremental integer-sqrt walk.
// Optional DELAY_CLAMP_EN: saturate d at its maximum and raise the sticky sat flag instead of wrapping.
module element_delay_tracker #(
  parameter int unsigned DW_INTEGER  = 18,
  parameter int unsigned DW_FRACTION = 3,
  parameter int unsigned DELAY_DW    = 12,
  parameter int unsigned N_TERMS     = 32,
  parameter int unsigned IDX_DW      = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  initiate,
  input  logic [DELAY_DW-1:0]                   d_0,
  input  logic [DW_INTEGER+DW_FRACTION:0]       term,
  input  logic                                  term_ready,
  output logic                                  term_ack,
  output logic [DELAY_DW-1:0]                   delay_out,
  output logic [IDX_DW-1:0]                     delay_idx,
  output logic                                  delay_valid,
  input  logic                                  delay_ack,
  output logic                                  delay_last,
  output logic                                  sat,
  output logic                                  busy
);

  localparam int unsigned TW = DW_INTEGER + DW_FRACTION + 1;
  localparam int unsigned EW = TW + 2;
  localparam logic [IDX_DW-1:0] LAST_IDX = IDX_DW'(N_TERMS);

  typedef enum logic [1:0] {IDLE, EMIT, FETCH, ADJUST} state_t;

  state_t                     state, state_n;
  logic [DELAY_DW-1:0]        d_q, d_n;
  logic signed [EW-1:0]       e_q, e_n;
  logic [IDX_DW-1:0]          idx_q, idx_n;
  logic signed [EW-1:0]       t_up, t_dn, term_ext;

  // Thresholds (2d+1) and (2d-1) at the term's binary point; t_dn only matters when d > 0
  always_comb begin
    t_up     = EW'({d_q, 1'b1}) << DW_FRACTION;
    t_dn     = (EW'({d_q, 1'b0}) - EW'(1)) << DW_FRACTION;
    term_ext = {{(EW-TW){term[TW-1]}}, term};
  end

`ifdef DELAY_CLAMP_EN
  logic sat_q, sat_n;
`endif

  // Next-state logic; term_ack is a same-cycle capture strobe for the producer
  always_comb begin
    state_n  = state;
    d_n      = d_q;
    e_n      = e_q;
    idx_n    = idx_q;
    term_ack = 1'b0;
`ifdef DELAY_CLAMP_EN
    sat_n    = sat_q;
`endif
    case (state)
      IDLE: begin
        if (initiate) begin
          d_n     = d_0;
          e_n     = '0;
          idx_n   = '0;
`ifdef DELAY_CLAMP_EN
          sat_n   = 1'b0;
`endif
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (delay_ack) begin
          state_n = (idx_q == LAST_IDX) ? IDLE : FETCH;
        end
      end
      FETCH: begin
        if (term_ready) begin
          e_n      = e_q + term_ext;
          idx_n    = idx_q + IDX_DW'(1);
          term_ack = 1'b1;
          state_n  = ADJUST;
        end
      end
      ADJUST: begin
        if (e_q >= t_up) begin
`ifdef DELAY_CLAMP_EN
          if (d_q == {DELAY_DW{1'b1}}) begin
            sat_n   = 1'b1;
            state_n = EMIT;
          end else begin
            e_n = e_q - t_up;
            d_n = d_q + DELAY_DW'(1);
          end
`else
          e_n = e_q - t_up;
          d_n = d_q + DELAY_DW'(1);
`endif
        end else if ((e_q < -t_dn) && (d_q != '0)) begin
          e_n = e_q + t_dn;
          d_n = d_q - DELAY_DW'(1);
        end else begin
          state_n = EMIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; outputs are zero whenever no delay is being offered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      d_q         <= '0;
      e_q         <= '0;
      idx_q       <= '0;
      delay_valid <= 1'b0;
      delay_out   <= '0;
      delay_idx   <= '0;
      delay_last  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      d_q         <= d_n;
      e_q         <= e_n;
      idx_q       <= idx_n;
      delay_valid <= (state_n == EMIT);
      delay_out   <= (state_n == EMIT) ? d_n : '0;
      delay_idx   <= (state_n == EMIT) ? idx_n : '0;
      delay_last  <= (state_n == EMIT) && (idx_n == LAST_IDX);
      busy        <= (state_n != IDLE);
    end
  end

`ifdef DELAY_CLAMP_EN
  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_n;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

endmodule
